// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - programmable countdown timer driven by rising edges of a slow divided signal
//
// Purpose:
//   Samples slow_in in the clk domain and turns each rising edge into a one-cycle tick.
//   While running, the loaded count is decremented once per tick. done pulses and expired
//   is set when the count runs out. With AUTO_RELOAD=1 the stored load value is reloaded
//   and counting continues.
//
// Ports:
//   clk       in   system clock (the only clock in the block)
//   rst_n     in   asynchronous active-low reset
//   slow_in   in   divided square wave, asynchronous to clk, sampled as data
//   load      in   one-cycle strobe, loads load_val into count and the reload register
//   load_val  in   [WIDTH-1:0] value to load
//   start     in   one-cycle strobe, begin or resume counting
//   pause     in   one-cycle strobe, suspend counting
//   count     out  [WIDTH-1:0] current count
//   running   out  high while in RUN
//   done      out  one-cycle pulse on expiry
//   expired   out  sticky expiry flag, cleared by load or reset

module countdown_timer #(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             expired
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_tick;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_running;
  logic             r_done;
  logic             r_expired;

  // r_s1/r_s2 resynchronise slow_in; r_s3 holds the previous r_s2 for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= slow_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // One cycle per rising edge; falling edges are ignored.
  assign w_tick = r_s2 & ~r_s3;

  // Control FSM with registered outputs. Priority: load > pause > start > tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        // Any tick in this cycle is dropped.
        r_count   <= load_val;
        r_reload  <= load_val;
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
        r_expired <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // A zero count cannot be started.
            if (start && (r_count != '0)) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end

          ST_RUN: begin
            if (pause) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end else if (w_tick) begin
              if (r_count > ONE) begin
                r_count <= r_count - ONE;
              end else if (r_count == ONE) begin
                r_done    <= 1'b1;
                r_expired <= 1'b1;
                if (AUTO_RELOAD && (r_reload != '0)) begin
                  r_count <= r_reload;
                end else begin
                  r_count   <= '0;
                  r_state   <= ST_IDLE;
                  r_running <= 1'b0;
                end
              end
            end
          end

          ST_PAUSE: begin
            // pause beats a simultaneous start; ticks here and on resume are dropped.
            if (start && !pause) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end

          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign done    = r_done;
  assign expired = r_expired;

endmodule
